incline_cond: RTL and testbench
===============================

# incline_cond

Downstream conditioning stage for the inertial interface: consumes the raw signed `incline` samples and their `vld` strobe and produces a smoothed, saturated incline for the assist-torque math. It also flags stale data when the sensor stops delivering samples. It sits between `inert_intf` and the sensor-conditioning and assist logic.

## Interface
- `FAST_SIM`, default 0: 1 shortens the stale watchdog for simulation.
- `AVG_SHIFT`, default 4: exponential-average weight is 1/2^AVG_SHIFT. Legal range is 2..6.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `vld` in 1: single-cycle strobe; `incline` is valid in the cycle `vld` is high.
- `incline` in 13: signed raw incline sample.
- `avg_incline` out 13: signed smoothed incline.
- `incline_sat` out 10: signed `avg_incline` saturated to the range -512..511.
- `avg_vld` out 1: one-cycle pulse; `avg_incline` and `incline_sat` were just updated.
- `stale` out 1: high when there is no trustworthy data (after reset, or after a timeout).

## Operation
- States:
  - IDLE: no sample since reset.
  - RUN: samples arriving.
  - STALE: watchdog expired.
- Accumulator `accum` is signed, 13+AVG_SHIFT bits. `avg = accum >>> AVG_SHIFT`, which is an arithmetic shift (floor toward negative infinity).
- In IDLE or STALE, `vld` seeds the accumulator with `accum <= sext(incline) << AVG_SHIFT`. The average therefore equals the sample immediately. State goes to RUN and `stale` clears.
- In RUN, `vld` updates with `accum <= accum - (accum >>> AVG_SHIFT) + sext(incline)`. This cannot overflow at the chosen width.
- Saturation: if `avg` > 511, `incline_sat` = 511. If `avg` < -512, `incline_sat` = -512. Otherwise `incline_sat` = `avg[9:0]`.
- Watchdog:
  - Counter width is 20 bits (12 bits if FAST_SIM). TERM is all ones.
  - The counter clears on every `vld` and increments each RUN cycle without `vld`.
  - In RUN with the counter at TERM and no `vld`, state goes to STALE and `stale` is set to 1.
  - The counter holds in IDLE and STALE.
- In STALE, `avg_incline` and `incline_sat` hold their last values.
- Simultaneous events: `vld` in the same cycle as the terminal count means `vld` wins. The state stays in RUN, the counter clears, and `stale` stays 0.

## Timing
- Reset values:
  - `avg_incline` = 0.
  - `incline_sat` = 0.
  - `avg_vld` = 0.
  - `stale` = 1.
  - State = IDLE.
  - `accum` = 0.
  - Watchdog counter = 0.
- Latency:
  - `vld` sampled at edge N causes `avg_incline`, `incline_sat` and `avg_vld` to update at edge N (registered outputs).
  - They are valid in the cycle after edge N. `avg_vld` is high for exactly that one cycle.
- Back-to-back `vld` on consecutive cycles is supported. Each one is processed, giving one `avg_vld` per `vld`.
- `stale` rises at the 2^20th rising edge after the edge that sampled the last `vld` (2^12th if FAST_SIM). It falls at the edge that samples the next `vld`.
- Reset asserted mid-operation forces all reset values immediately. The next `vld` after reset release is treated as a seed.
- `incline` is ignored when `vld` is low.

## Test plan
- Seed: after reset, `vld` with `incline`=100. Required response: `avg_incline`=100, `incline_sat`=100, `avg_vld` pulses once, `stale` 1→0.
- Decay (AVG_SHIFT=4): seed 100, then `vld` with 0. Required response: accum = 1600 - 100 = 1500, so `avg_incline`=93. A second 0 sample gives 1500 - 93 = 1407, so `avg_incline`=87.
- Negative floor: seed -1, then `vld` with 0. Required response: accum = -15, so `avg_incline`=-1, `incline_sat`=-1.
- Saturation: seed 1000. Required response: `avg_incline`=1000, `incline_sat`=511. Reset, then seed -1000. Required response: `incline_sat`=-512.
- Watchdog (FAST_SIM=1): seed 50, then no `vld`. Required response: `stale` rises exactly 4096 edges after the seed edge. A subsequent `vld` with -20 reseeds: `avg_incline`=-20, `stale`=0.
- Race and reset:
  - Assert `vld` with 30 on the terminal-count cycle. Required response: `stale` stays 0 and the RUN update is applied.
  - Assert `rst_n` low mid-stream. Required response: all outputs return to reset values asynchronously, with `stale`=1.

Source files
------------

// File: rtl/incline_cond.sv
// Incline conditioning: exponential smoothing of raw incline samples, saturation
// to a 10-bit signed range, and a stale-data watchdog when samples stop arriving.
module incline_cond #(
  parameter int FAST_SIM  = 0,
  parameter int AVG_SHIFT = 4   // smoothing weight 1/2^AVG_SHIFT, usable range 2..6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [12:0] incline,
  output logic [12:0] avg_incline,
  output logic [9:0]  incline_sat,
  output logic        avg_vld,
  output logic        stale,
  output logic [1:0]  dbg_state
);

  localparam int AW = 13 + AVG_SHIFT;
  localparam int CW = (FAST_SIM != 0) ? 12 : 20;

  localparam logic signed [12:0] SAT_HI = 13'sd511;
  localparam logic signed [12:0] SAT_LO = -13'sd512;

  // Handshake: vld is a single-cycle strobe qualifying incline in that cycle;
  // avg_vld pulses for one cycle after each vld, with outputs already updated.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   accum_q, accum_d;
  logic        [CW-1:0]   cnt_q, cnt_d;
  logic        [12:0]     avg_q, avg_d;
  logic        [9:0]      sat_q, sat_d;
  logic                   avg_vld_q, avg_vld_d;
  logic                   stale_q, stale_d;

  logic signed [AW-1:0]   accum_shr;
  logic signed [AW-1:0]   sample_ext;
  logic signed [AW-1:0]   seed_val;
  logic signed [AW-1:0]   run_val;
  logic signed [12:0]     avg_new;
  logic                   wd_term;
  logic                   new_sample;

  // Accumulator holds avg scaled by 2^AVG_SHIFT, so the top 13 bits are the average.
  assign accum_shr  = accum_q >>> AVG_SHIFT;
  assign sample_ext = {{AVG_SHIFT{incline[12]}}, incline};
  assign seed_val   = {incline, {AVG_SHIFT{1'b0}}};
  assign run_val    = accum_q - accum_shr + sample_ext;
  assign wd_term    = (cnt_q == {CW{1'b1}});

  always_comb begin
    state_d    = state_q;
    accum_d    = accum_q;
    cnt_d      = cnt_q;
    stale_d    = stale_q;
    new_sample = 1'b0;
    case (state_q)
      IDLE, STALE: begin
        if (vld) begin
          accum_d    = seed_val;
          cnt_d      = '0;
          state_d    = RUN;
          stale_d    = 1'b0;
          new_sample = 1'b1;
        end
      end
      RUN: begin
        // A sample arriving on the terminal-count cycle keeps the stream alive.
        if (vld) begin
          accum_d    = run_val;
          cnt_d      = '0;
          new_sample = 1'b1;
        end else if (wd_term) begin
          state_d = STALE;
          stale_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        stale_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    avg_new   = accum_d[AW-1:AVG_SHIFT];
    avg_d     = avg_q;
    sat_d     = sat_q;
    avg_vld_d = 1'b0;
    if (new_sample) begin
      avg_d     = avg_new;
      avg_vld_d = 1'b1;
      if (avg_new > SAT_HI) begin
        sat_d = 10'h1FF;
      end else if (avg_new < SAT_LO) begin
        sat_d = 10'h200;
      end else begin
        sat_d = avg_new[9:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      accum_q   <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      sat_q     <= '0;
      avg_vld_q <= 1'b0;
      stale_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      accum_q   <= accum_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      sat_q     <= sat_d;
      avg_vld_q <= avg_vld_d;
      stale_q   <= stale_d;
    end
  end

  assign avg_incline = avg_q;
  assign incline_sat = sat_q;
  assign avg_vld     = avg_vld_q;
  assign stale       = stale_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_incline_cond.sv
// Bench for incline_cond: directed vector table, watchdog/race sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_incline_cond;

  localparam int WD_EDGES = 4096;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [12:0] incline;
  logic [12:0] avg_incline;
  logic [9:0]  incline_sat;
  logic        avg_vld;
  logic        stale;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  incline_cond #(.FAST_SIM(1), .AVG_SHIFT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld        (vld),
    .incline    (incline),
    .avg_incline(avg_incline),
    .incline_sat(incline_sat),
    .avg_vld    (avg_vld),
    .stale      (stale),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  int m_accum;
  bit m_run;
  bit m_stale;
  int m_since;
  int m_avg;
  int m_sat;
  bit m_vld;

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(int a);
    if (a > 511) return 511;
    if (a < -512) return -512;
    return a;
  endfunction

  task automatic model_reset();
    m_accum = 0; m_run = 0; m_stale = 1; m_since = 0;
    m_avg = 0; m_sat = 0; m_vld = 0;
  endtask

  task automatic model_step(input bit v, input int x);
    if (v) begin
      if (!m_run) m_accum = x * 16;
      else        m_accum = m_accum - fdiv(m_accum, 16) + x;
      m_run = 1; m_stale = 0; m_since = 0;
      m_avg = fdiv(m_accum, 16);
      m_sat = clamp(m_avg);
      m_vld = 1;
    end else begin
      m_vld = 0;
      if (m_run) begin
        m_since++;
        if (m_since == WD_EDGES) begin
          m_run = 0;
          m_stale = 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".avg_incline"}, $signed(avg_incline), m_avg);
    cmp({tag, ".incline_sat"}, $signed(incline_sat), m_sat);
    cmp({tag, ".avg_vld"}, int'(avg_vld), int'(m_vld));
    cmp({tag, ".stale"}, int'(stale), int'(m_stale));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit v, input int x, input bit chk);
    vld = v;
    incline = x[12:0];
    @(posedge clk);
    model_step(v, x);
    #1;
    if (chk) check_all("step");
  endtask

  // Async reset pulse entirely between clock edges.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    vld = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit rst;
    bit v;
    int x;
    int e_avg;
    int e_sat;
    bit e_vld;
    bit e_stale;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int edge_n;
    int k;

    vecs[0]  = '{1, 0, 0,     0,     0,    0, 1};
    vecs[1]  = '{0, 1, 100,   100,   100,  1, 0};
    vecs[2]  = '{0, 1, 0,     93,    93,   1, 0};
    vecs[3]  = '{0, 1, 0,     87,    87,   1, 0};
    vecs[4]  = '{0, 0, 555,   87,    87,   0, 0};
    vecs[5]  = '{1, 0, 0,     0,     0,    0, 1};
    vecs[6]  = '{0, 1, -1,    -1,    -1,   1, 0};
    vecs[7]  = '{0, 1, 0,     -1,    -1,   1, 0};
    vecs[8]  = '{1, 0, 0,     0,     0,    0, 1};
    vecs[9]  = '{0, 1, 1000,  1000,  511,  1, 0};
    vecs[10] = '{0, 0, -77,   1000,  511,  0, 0};
    vecs[11] = '{1, 0, 0,     0,     0,    0, 1};
    vecs[12] = '{0, 1, -1000, -1000, -512, 1, 0};
    vecs[13] = '{0, 1, 4095,  -682,  -512, 1, 0};

    rst_n = 1'b0;
    vld = 1'b0;
    incline = '0;
    model_reset();
    #23;
    check_all("reset");
    #4;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) pulse_reset();
      else step(vecs[i].v, vecs[i].x, 0);
      cmp($sformatf("vec%0d.avg", i), $signed(avg_incline), vecs[i].e_avg);
      cmp($sformatf("vec%0d.sat", i), $signed(incline_sat), vecs[i].e_sat);
      cmp($sformatf("vec%0d.vld", i), int'(avg_vld), int'(vecs[i].e_vld));
      cmp($sformatf("vec%0d.stale", i), int'(stale), int'(vecs[i].e_stale));
    end

    // Watchdog: stale must rise exactly WD_EDGES edges after the seed edge.
    pulse_reset();
    step(1, 50, 1);
    edge_n = 0;
    k = 0;
    while (k < 5000 && edge_n == 0) begin
      k++;
      step(0, rnd_sample(), 1);
      if (stale) edge_n = k;
    end
    cmp("wd_rise_edge", edge_n, WD_EDGES);
    cmp("wd_hold_avg", $signed(avg_incline), 50);
    step(1, -20, 1);
    cmp("reseed_avg", $signed(avg_incline), -20);
    cmp("reseed_stale", int'(stale), 0);

    // Race: vld lands on the terminal-count cycle.
    for (int i = 1; i < WD_EDGES; i++) step(0, rnd_sample(), 1);
    cmp("race_pre_stale", int'(stale), 0);
    step(1, 30, 1);
    cmp("race_stale", int'(stale), 0);
    cmp("race_vld", int'(avg_vld), 1);
    cmp("race_avg", $signed(avg_incline), fdiv(-320 + 20 + 30, 16));

    // Randomized traffic with occasional mid-stream async resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) pulse_reset();
      step(($urandom_range(0, 99) < 55), rnd_sample(), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
